// File: rtl/scale_div.sv
// Vector-by-scalar signed fixed-point divider: out[i] = (x[i] << Q_BITS) / a, three lanes,
// one quotient bit per cycle, results queued in an internal first-word-fall-through FIFO.

module fifo_array #(
    parameter int ARRAY_SIZE = 3,
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din  [ARRAY_SIZE],
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout [ARRAY_SIZE],
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = ARRAY_SIZE * WIDTH;

    logic [PW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [PW-1:0] din_packed_s;
    logic [PW-1:0] head_s;
    logic          wr_ok_s;
    logic          rd_ok_s;

    // Flow control and lane packing/unpacking; the head reads zero while empty.
    always_comb begin
        full         = (count_r == (AW+1)'(DEPTH));
        empty        = (count_r == (AW+1)'(0));
        wr_ok_s      = wr_en && !full;
        rd_ok_s      = rd_en && !empty;
        head_s       = mem_r[rd_ptr_r];
        din_packed_s = {PW{1'b0}};
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            din_packed_s[i*WIDTH +: WIDTH] = din[i];
            if (empty) begin
                dout[i] = {WIDTH{1'b0}};
            end else begin
                dout[i] = head_s[i*WIDTH +: WIDTH];
            end
        end
    end

    // Storage array, written only when there is room.
    always_ff @(posedge clock) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= din_packed_s;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= (wr_ptr_r == AW'(DEPTH-1)) ? {AW{1'b0}} : wr_ptr_r + AW'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= (rd_ptr_r == AW'(DEPTH-1)) ? {AW{1'b0}} : rd_ptr_r + AW'(1);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

module scale_div #(
    parameter int Q_BITS     = 16,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [31:0] x [3],
    input  logic signed [31:0] a,
    input  logic               in_empty,
    output logic               in_rd_en,
    output logic signed [31:0] out [3],
    output logic               out_empty,
    input  logic               out_rd_en
);
    localparam int DW = 32 + Q_BITS;
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        SAT  = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r;
    logic [DW-1:0] dvd_r   [3];
    logic [DW-1:0] quo_r   [3];
    logic [32:0]   rem_r   [3];
    logic [31:0]   din_r   [3];
    logic [31:0]   abs_a_r;
    logic [2:0]    neg_r;
    logic [2:0]    xz_r;
    logic          az_r;
    logic [32:0]   rem_nxt_s [3];
    logic [2:0]    qbit_s;
    logic          out_wr_en_s;
    logic          fifo_full_s;
    logic [31:0]   fifo_dout_s [3];

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    // Sign/zero/saturation post-processing of one lane's unsigned quotient.
    function automatic logic [31:0] sat_lane(input logic [DW-1:0] q, input logic neg,
                                             input logic xz, input logic az);
        logic [31:0] r;
        if (xz) begin
            r = 32'd0;
        end else if (az) begin
            r = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (!neg) begin
            r = (q > DW'(32'h7FFF_FFFF)) ? 32'h7FFF_FFFF : q[31:0];
        end else begin
            r = (q > DW'(32'h8000_0000)) ? 32'h8000_0000 : (32'd0 - q[31:0]);
        end
        return r;
    endfunction

    // One restoring-division step per lane; with a=0 the result is overridden in SAT.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            logic [32:0] sh;
            sh = {rem_r[i][31:0], dvd_r[i][DW-1]};
            if (sh >= {1'b0, abs_a_r}) begin
                rem_nxt_s[i] = sh - {1'b0, abs_a_r};
                qbit_s[i]    = 1'b1;
            end else begin
                rem_nxt_s[i] = sh;
                qbit_s[i]    = 1'b0;
            end
        end
    end

    // Controller next state and handshake strobes.
    always_comb begin
        state_s     = state_r;
        in_rd_en    = 1'b0;
        out_wr_en_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!in_empty && !reset) begin
                    in_rd_en = 1'b1;
                    state_s  = DIV;
                end else begin
                    state_s = IDLE;
                end
            end
            DIV: begin
                if (cnt_r == LAST) begin
                    state_s = SAT;
                end else begin
                    state_s = DIV;
                end
            end
            SAT: state_s = WR;
            WR: begin
                if (!fifo_full_s) begin
                    out_wr_en_s = 1'b1;
                    state_s     = IDLE;
                end else begin
                    state_s = WR;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: operand capture, iteration, and result registration.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r   <= {CW{1'b0}};
            abs_a_r <= 32'd0;
            neg_r   <= 3'd0;
            xz_r    <= 3'd0;
            az_r    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                dvd_r[i] <= {DW{1'b0}};
                quo_r[i] <= {DW{1'b0}};
                rem_r[i] <= 33'd0;
                din_r[i] <= 32'd0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_rd_en) begin
                        cnt_r   <= {CW{1'b0}};
                        abs_a_r <= abs32(a);
                        az_r    <= (a == 32'sd0);
                        for (int i = 0; i < 3; i++) begin
                            dvd_r[i] <= {abs32(x[i]), {Q_BITS{1'b0}}};
                            quo_r[i] <= {DW{1'b0}};
                            rem_r[i] <= 33'd0;
                            neg_r[i] <= x[i][31] ^ a[31];
                            xz_r[i]  <= (x[i] == 32'sd0);
                        end
                    end
                end
                DIV: begin
                    cnt_r <= cnt_r + CW'(1);
                    for (int i = 0; i < 3; i++) begin
                        dvd_r[i] <= {dvd_r[i][DW-2:0], 1'b0};
                        rem_r[i] <= rem_nxt_s[i];
                        quo_r[i] <= {quo_r[i][DW-2:0], qbit_s[i]};
                    end
                end
                SAT: begin
                    for (int i = 0; i < 3; i++) begin
                        din_r[i] <= sat_lane(quo_r[i], neg_r[i], xz_r[i], az_r);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    fifo_array #(
        .ARRAY_SIZE (3),
        .WIDTH      (32),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .wr_en (out_wr_en_s),
        .din   (din_r),
        .full  (fifo_full_s),
        .rd_en (out_rd_en),
        .dout  (fifo_dout_s),
        .empty (out_empty)
    );

    // Present the FIFO head as signed lanes.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            out[i] = fifo_dout_s[i];
        end
    end
endmodule

// File: tb/tb_scale_div.sv
// Directed self-checking bench for scale_div (FIFO_DEPTH=4 so backpressure is reachable).

module tb_scale_div;
    logic               clock = 1'b0;
    logic               reset;
    logic signed [31:0] x [3];
    logic signed [31:0] a;
    logic               in_empty;
    logic               in_rd_en;
    logic signed [31:0] out [3];
    logic               out_empty;
    logic               out_rd_en;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] x0, x1, x2, a;
    } vec_t;
    vec_t upq[$];

    always #5 clock = ~clock;

    scale_div #(.Q_BITS(16), .FIFO_DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .x         (x),
        .a         (a),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .out       (out),
        .out_empty (out_empty),
        .out_rd_en (out_rd_en)
    );

    // Upstream first-word-fall-through FIFO model.
    initial begin
        bit pend;
        pend = 1'b0;
        in_empty = 1'b1;
        x[0] = 32'd0; x[1] = 32'd0; x[2] = 32'd0; a = 32'd0;
        forever begin
            @(negedge clock);
            if (pend && upq.size() > 0) void'(upq.pop_front());
            if (upq.size() > 0) begin
                in_empty = 1'b0;
                x[0] = upq[0].x0; x[1] = upq[0].x1; x[2] = upq[0].x2; a = upq[0].a;
            end else begin
                in_empty = 1'b1;
            end
            #1 pend = in_rd_en;
        end
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] x0, x1, x2, av);
        vec_t v;
        v.x0 = x0; v.x1 = x1; v.x2 = x2; v.a = av;
        upq.push_back(v);
    endtask

    task automatic wait_pop(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clock); #2; n++;
        end while (!in_rd_en && n < 300);
        check32({tag, "_pop"}, {31'd0, in_rd_en}, 32'd1);
    endtask

    task automatic wait_out(input string tag, output int lat);
        lat = 0;
        do begin
            @(negedge clock); #2; lat++;
        end while (out_empty && lat < 300);
        check32({tag, "_ready"}, {31'd0, out_empty}, 32'd0);
    endtask

    task automatic check_head(input string tag, input logic [31:0] e0, e1, e2);
        check32({tag, "_out0"}, out[0], e0);
        check32({tag, "_out1"}, out[1], e1);
        check32({tag, "_out2"}, out[2], e2);
    endtask

    task automatic pop_head();
        out_rd_en = 1'b1;
        @(posedge clock); #1;
        out_rd_en = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [31:0] x0, x1, x2, av,
                           input logic [31:0] e0, e1, e2);
        int lat;
        push(x0, x1, x2, av);
        wait_pop(tag);
        wait_out(tag, lat);
        check32({tag, "_latency"}, 32'(lat), 32'd51);
        check_head(tag, e0, e1, e2);
        pop_head();
        @(negedge clock); #2;
        check32({tag, "_drained"}, {31'd0, out_empty}, 32'd1);
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        out_rd_en = 1'b0;
        repeat (3) @(negedge clock);
        #2;
        check32("rst_out_empty", {31'd0, out_empty}, 32'd1);
        check32("rst_in_rd_en", {31'd0, in_rd_en}, 32'd0);
        check_head("rst", 32'd0, 32'd0, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_vec("basic", 32'h0001_0000, 32'hFFFE_0000, 32'h0000_8000, 32'h0002_0000,
                32'h0000_8000, 32'hFFFF_0000, 32'h0000_4000);
        run_vec("trunc", 32'h0001_0000, 32'hFFFF_0000, 32'h8000_0000, 32'h0003_0000,
                32'h0000_5555, 32'hFFFF_AAAB, 32'hD555_5556);
        run_vec("divzero", 32'h0003_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000,
                32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000);
        run_vec("ovf", 32'h4000_0000, 32'hC000_0000, 32'h0000_0100, 32'h0000_0100,
                32'h7FFF_FFFF, 32'h8000_0000, 32'h0001_0000);
        run_vec("negdiv", 32'h0003_0000, 32'hFFFA_0000, 32'h0000_0001, 32'hFFFE_0000,
                32'hFFFE_8000, 32'h0003_0000, 32'h0000_0000);

        // Backpressure: six vectors into a depth-4 output FIFO with no pops.
        for (int k = 1; k <= 6; k++) begin
            push(32'(k) << 16, 32'd0 - (32'(k) << 16), 32'(k) << 15, 32'h0002_0000);
        end
        repeat (400) @(negedge clock);
        #2;
        check32("bp_upstream_left", 32'(upq.size()), 32'd1);
        check32("bp_no_pop", {31'd0, in_rd_en}, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            wait_out($sformatf("bp%0d", k), lat);
            check_head($sformatf("bp%0d", k), 32'(k) << 15, 32'd0 - (32'(k) << 15), 32'(k) << 14);
            pop_head();
        end
        @(negedge clock); #2;
        check32("bp_drained", {31'd0, out_empty}, 32'd1);

        // Reset in the middle of a division, with one result already queued.
        push(32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0001_0000);
        wait_pop("rstA");
        wait_out("rstA", lat);
        check32("rstA_out0", out[0], 32'h0002_0000);
        push(32'h0005_0000, 32'h0005_0000, 32'h0005_0000, 32'h0001_0000);
        push(32'h0007_0000, 32'hFFF9_0000, 32'h0000_0000, 32'h0002_0000);
        wait_pop("rstB");
        repeat (20) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check32("rst_mid_in_rd_en", {31'd0, in_rd_en}, 32'd0);
        check32("rst_mid_out_empty", {31'd0, out_empty}, 32'd1);
        check32("rst_mid_out0", out[0], 32'd0);
        repeat (3) @(negedge clock);
        #2;
        check32("rst_hold_out_empty", {31'd0, out_empty}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        #2;
        check32("rst_repop", {31'd0, in_rd_en}, 32'd1);
        wait_out("rstC", lat);
        check32("rstC_latency", 32'(lat), 32'd51);
        check_head("rstC", 32'h0003_8000, 32'hFFFC_8000, 32'h0000_0000);
        pop_head();
        @(negedge clock); #2;
        check32("rstC_drained", {31'd0, out_empty}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
